vec_mem_req_arbiter: RTL
========================

VEC_MEM_REQ_ARBITER -- requirements
Module: vec_mem_req_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of vector load/store units sharing one memory port, 2..8.
REQ-002 Parameter BASE_CORE_ID, default 8: core_id of requester 0; requester i owns core_id BASE_CORE_ID+i.
REQ-003 Parameter MAX_BURST, default 8: grant-hold limit, used only with VEC_ARB_BURST_LOCK_EN.
REQ-004 clk  input  1  single clock, all logic on posedge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_in  input  request_t[NUM_REQ]  per-requester memory request; vld held until granted.
REQ-007 req_grant  output  NUM_REQ  one-hot accept pulse to requester i, same cycle as acceptance.
REQ-008 mem_req  output  request_t  registered request to memory.
REQ-009 mem_req_grant  input  1  memory accepts mem_req this cycle.
REQ-010 mem_rsp  input  request_t  memory response, routed by core_id.
REQ-011 rsp_out  output  request_t[NUM_REQ]  per-requester response.
REQ-012 rsp_drop  output  1  pulse: response had out-of-range core_id.

Function
REQ-013 Output slot open when mem_req.vld=0 or mem_req_grant=1 in the same cycle.
REQ-014 When the slot is open and any req_in[i].vld=1, exactly one winner shall be chosen, req_grant[winner]=1 combinationally, and req_in[winner] shall load into mem_req on the next edge.
REQ-015 When the slot is not open, req_grant shall be all-zero.
REQ-016 Round-robin: search starts at last_ptr+1 modulo NUM_REQ; last_ptr updates to winner on each grant.
REQ-017 mem_req shall be held stable, vld=1, until mem_req_grant; with grant and no new winner, mem_req shall clear to 0 next edge.
REQ-018 Grant and back-to-back reload in the same cycle shall give zero bubble: one request per cycle sustained when mem_req_grant is held high.
REQ-019 Arbiter shall not alter any request_t field; core_id passes through unchanged.
REQ-020 Response routing: when mem_rsp.vld and 0 <= core_id-BASE_CORE_ID < NUM_REQ, rsp_out[idx] shall equal mem_rsp one cycle later; all other rsp_out shall be 0.
REQ-021 Out-of-range core_id: no rsp_out asserted; rsp_drop=1 for one cycle, registered with the same one-cycle latency.
REQ-022 Response path shall be independent of the request path; simultaneous grant and response in one cycle are both serviced.
REQ-023 A requester dropping vld without a grant is legal; it is not granted.

Reset
REQ-024 On reset: mem_req=0, rsp_out all 0, rsp_drop=0, last_ptr=NUM_REQ-1 (so requester 0 wins first), burst counter=0.
REQ-025 req_grant shall be 0 while reset is asserted.
REQ-026 Reset mid-transfer discards the held mem_req; the first grant after reset shall go to the lowest-index valid requester.

Configuration
REQ-027 Macro VEC_ARB_BURST_LOCK_EN defined: after a grant to requester i, i keeps priority on subsequent open slots while req_in[i].vld=1, up to MAX_BURST consecutive grants; then round-robin resumes from i+1. A vld drop ends the burst early.
REQ-028 Macro undefined: pure round-robin per REQ-016; no burst counter is synthesized.

Structure
REQ-029 request_t, READ_REQ/WRITE_REQ and core-id width belong in the shared vector package; NUM_REQ-dependent types stay local.
REQ-030 One sub-module, vec_rr_arbiter (combinational round-robin pick from a request vector and pointer), is instantiated once.

Verification
REQ-031 Reset then req_in[0..3].vld=1, mem_req_grant=1 held -> grants 0,1,2,3,0 on consecutive cycles; mem_req.core_id 8,9,10,11,8.
REQ-032 Single req_in[2] valid, mem_req_grant=0 for 3 cycles -> one req_grant[2] pulse; mem_req stable 3 cycles; clears the cycle after grant.
REQ-033 mem_rsp.vld with core_id=10 -> rsp_out[2].vld=1 next cycle, others 0; core_id=20 -> rsp_drop pulse, no rsp_out.
REQ-034 VEC_ARB_BURST_LOCK_EN, MAX_BURST=8, req 1 and 3 held valid -> 8 consecutive grants to 1, then a grant to 3.
REQ-035 Reset asserted while mem_req.vld=1 and requests pending -> mem_req=0 immediately; after release the first grant goes to requester 0.
REQ-036 Simultaneous mem_req_grant, new winner and mem_rsp -> new request loaded, response routed, no lost event.

Source files
------------

// File: rtl/vec_mem_req_arbiter_pkg.sv
// Shared vector memory request types: the request/response payload and the op encoding.
package vec_mem_req_arbiter_pkg;

  localparam int unsigned CORE_ID_W = 8;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;

  typedef enum logic {
    READ_REQ  = 1'b0,
    WRITE_REQ = 1'b1
  } req_op_e;

  typedef struct packed {
    logic                 vld;
    req_op_e              op;
    logic [CORE_ID_W-1:0] core_id;
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    data;
  } request_t;

endpackage

// File: rtl/vec_mem_req_arbiter_if.sv
// Bundle of requester, memory-port and response signals around the arbiter.
interface vec_mem_req_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
) ();
  import vec_mem_req_arbiter_pkg::*;

  request_t [NUM_REQ-1:0] req_in;
  logic     [NUM_REQ-1:0] req_grant;
  request_t               mem_req;
  logic                   mem_req_grant;
  request_t               mem_rsp;
  request_t [NUM_REQ-1:0] rsp_out;
  logic                   rsp_drop;

  // Requesters and memory side drive requests, memory grant and responses.
  modport master (
    output req_in, mem_req_grant, mem_rsp,
    input  req_grant, mem_req, rsp_out, rsp_drop
  );

  // Arbiter side.
  modport slave (
    input  req_in, mem_req_grant, mem_rsp,
    output req_grant, mem_req, rsp_out, rsp_drop
  );

endinterface

// File: rtl/vec_rr_arbiter.sv
// Combinational round-robin pick: first set bit of req_i searching upward from ptr_i+1.
module vec_rr_arbiter
  import vec_mem_req_arbiter_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic                 any_o,
  output logic [$clog2(N)-1:0] idx_o
);

  localparam int unsigned PTR_W = $clog2(N);

  int unsigned cand;

  always_comb begin
    any_o = 1'b0;
    idx_o = ptr_i;
    cand  = 0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = (32'(ptr_i) + off) % N;
      if (!any_o && req_i[PTR_W'(cand)]) begin
        any_o = 1'b1;
        idx_o = PTR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/vec_mem_req_arbiter.sv
// N-to-1 vector memory request arbiter with core_id-routed response return.
// Optional burst priority hold enabled by defining VEC_ARB_BURST_LOCK_EN.
module vec_mem_req_arbiter
  import vec_mem_req_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned BASE_CORE_ID = 8,
  parameter int unsigned MAX_BURST    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  vec_mem_req_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1) begin : g_bad_cfg
    $error("vec_mem_req_arbiter: unsupported NUM_REQ or MAX_BURST");
  end

  request_t               mem_req_q, mem_req_d;
  logic     [PTR_W-1:0]   last_ptr_q, last_ptr_d;
  request_t [NUM_REQ-1:0] rsp_out_q, rsp_out_d;
  logic                   rsp_drop_q, rsp_drop_d;

  logic [NUM_REQ-1:0] req_vld_c;
  logic               any_c;
  logic [PTR_W-1:0]   rr_idx_c;
  logic [PTR_W-1:0]   win_idx_c;
  logic               slot_open_c;
  logic               grant_c;

  always_comb begin
    req_vld_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) req_vld_c[i] = bus.req_in[i].vld;
  end

  vec_rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i (req_vld_c),
    .ptr_i (last_ptr_q),
    .any_o (any_c),
    .idx_o (rr_idx_c)
  );

  // Slot is free when empty or being drained this cycle, so reload is bubble-free.
  assign slot_open_c = !mem_req_q.vld || bus.mem_req_grant;
  assign grant_c     = slot_open_c && any_c && !reset;

`ifdef VEC_ARB_BURST_LOCK_EN
  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);

  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic               lock_c;

  // Last winner keeps the port while still requesting and under the burst limit.
  assign lock_c    = req_vld_c[last_ptr_q] && (burst_cnt_q != '0) &&
                     (burst_cnt_q < BURST_W'(MAX_BURST));
  assign win_idx_c = lock_c ? last_ptr_q : rr_idx_c;

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (grant_c) begin
      burst_cnt_d = lock_c ? burst_cnt_q + BURST_W'(1) : BURST_W'(1);
    end else if (!req_vld_c[last_ptr_q]) begin
      burst_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) burst_cnt_q <= '0;
    else       burst_cnt_q <= burst_cnt_d;
  end
`else
  assign win_idx_c = rr_idx_c;
`endif

  always_comb begin
    mem_req_d  = mem_req_q;
    last_ptr_d = last_ptr_q;
    if (grant_c) begin
      mem_req_d  = bus.req_in[win_idx_c];
      last_ptr_d = win_idx_c;
    end else if (bus.mem_req_grant) begin
      mem_req_d  = '0;
    end
  end

  // Response return path, independent of request arbitration.
  logic [CORE_ID_W-1:0] rsp_off_c;
  logic                 rsp_hit_c;

  assign rsp_off_c = bus.mem_rsp.core_id - CORE_ID_W'(BASE_CORE_ID);
  assign rsp_hit_c = (bus.mem_rsp.core_id >= CORE_ID_W'(BASE_CORE_ID)) &&
                     (rsp_off_c < CORE_ID_W'(NUM_REQ));

  always_comb begin
    rsp_out_d  = '0;
    rsp_drop_d = bus.mem_rsp.vld && !rsp_hit_c;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (bus.mem_rsp.vld && rsp_hit_c && (rsp_off_c == CORE_ID_W'(i))) begin
        rsp_out_d[i] = bus.mem_rsp;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req_q  <= '0;
      last_ptr_q <= PTR_W'(NUM_REQ - 1);
      rsp_out_q  <= '0;
      rsp_drop_q <= 1'b0;
    end else begin
      mem_req_q  <= mem_req_d;
      last_ptr_q <= last_ptr_d;
      rsp_out_q  <= rsp_out_d;
      rsp_drop_q <= rsp_drop_d;
    end
  end

  assign bus.req_grant = grant_c ? (NUM_REQ'(1) << win_idx_c) : '0;
  assign bus.mem_req   = mem_req_q;
  assign bus.rsp_out   = rsp_out_q;
  assign bus.rsp_drop  = rsp_drop_q;

endmodule
